// File: rtl/fp_align_add.sv
// Mantissa alignment and add/subtract stage ahead of round-to-nearest-even.
// Alignment shifts the smaller operand one bit per cycle, folding shifted-out bits into sticky.
module fp_align_add #(
  parameter int DATA_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op_a_sign,
  input  logic [EXP_W-1:0]    op_a_exp,
  input  logic [DATA_W-1:0]   op_a_man,
  input  logic                op_b_sign,
  input  logic [EXP_W-1:0]    op_b_exp,
  input  logic [DATA_W-1:0]   op_b_man,
  input  logic                sub,
  output logic                busy,
  output logic                done,
  output logic                sign_o,
  output logic [EXP_W-1:0]    exponent_o,
  output logic [DATA_W+2:0]   mantissa_o
);

  localparam int MW = DATA_W + 3;

  typedef enum logic [2:0] {IDLE, SWAP, ALIGN, ADD, FIX} state_t;

  state_t state, state_nxt;

  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp, diff;
  logic [MW-1:0]    a_man, b_man;
  logic [MW:0]      sum;

  logic             swap;
  logic             hi_sign, lo_sign;
  logic [EXP_W-1:0] hi_exp, lo_exp, swap_diff;
  logic [MW-1:0]    hi_man, lo_man;
  logic             far;

  // Operand ordering by {exp, man}; ties keep A in place
  always_comb begin
    swap      = {b_exp, b_man} > {a_exp, a_man};
    hi_sign   = swap ? b_sign : a_sign;
    hi_exp    = swap ? b_exp  : a_exp;
    hi_man    = swap ? b_man  : a_man;
    lo_sign   = swap ? a_sign : b_sign;
    lo_exp    = swap ? a_exp  : b_exp;
    lo_man    = swap ? a_man  : b_man;
    swap_diff = hi_exp - lo_exp;
    far       = 32'(swap_diff) >= 32'(MW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SWAP;
      SWAP:    state_nxt = (far || swap_diff == '0) ? ADD : ALIGN;
      ALIGN:   if (diff == EXP_W'(1)) state_nxt = ADD;
      ADD:     state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sign     <= 1'b0;
      a_exp      <= '0;
      a_man      <= '0;
      b_sign     <= 1'b0;
      b_exp      <= '0;
      b_man      <= '0;
      diff       <= '0;
      sum        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sign_o     <= 1'b0;
      exponent_o <= '0;
      mantissa_o <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_sign <= op_a_sign;
          a_exp  <= op_a_exp;
          a_man  <= {op_a_man, 3'b000};
          b_sign <= op_b_sign ^ sub;
          b_exp  <= op_b_exp;
          b_man  <= {op_b_man, 3'b000};
          busy   <= 1'b1;
        end
        SWAP: begin
          a_sign <= hi_sign;
          a_exp  <= hi_exp;
          a_man  <= hi_man;
          b_sign <= lo_sign;
          b_exp  <= lo_exp;
          b_man  <= far ? {{(MW-1){1'b0}}, |lo_man} : lo_man;
          diff   <= swap_diff;
        end
        ALIGN: begin
          b_man <= {1'b0, b_man[MW-1:2], b_man[1] | b_man[0]};
          diff  <= diff - 1'b1;
        end
        ADD: begin
          sum <= (a_sign == b_sign) ? {1'b0, a_man} + {1'b0, b_man}
                                    : {1'b0, a_man} - {1'b0, b_man};
        end
        FIX: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (sum[MW]) begin
            sign_o     <= a_sign;
            exponent_o <= (a_exp == '1) ? '1 : a_exp + 1'b1;
            mantissa_o <= {sum[MW:2], sum[1] | sum[0]};
          end else if (sum == '0) begin
            sign_o     <= 1'b0;
            exponent_o <= '0;
            mantissa_o <= '0;
          end else begin
            sign_o     <= a_sign;
            exponent_o <= a_exp;
            mantissa_o <= sum[MW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_add.sv
// Scoreboard bench for fp_align_add: a reference model predicts result and latency per request.
module tb_fp_align_add;

  localparam int DW = 24;
  localparam int EW = 8;
  localparam int MW = DW + 3;

  logic          clk, rst_n, start, sub;
  logic          op_a_sign, op_b_sign;
  logic [EW-1:0] op_a_exp, op_b_exp;
  logic [DW-1:0] op_a_man, op_b_man;
  logic          busy, done, sign_o;
  logic [EW-1:0] exponent_o;
  logic [MW-1:0] mantissa_o;

  fp_align_add #(.DATA_W(DW), .EXP_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a_sign(op_a_sign), .op_a_exp(op_a_exp), .op_a_man(op_a_man),
    .op_b_sign(op_b_sign), .op_b_exp(op_b_exp), .op_b_man(op_b_man),
    .sub(sub), .busy(busy), .done(done),
    .sign_o(sign_o), .exponent_o(exponent_o), .mantissa_o(mantissa_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          s;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    int            lat;
    int            t0;
  } res_t;

  res_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic as_i, input logic [EW-1:0] ae_i, input logic [DW-1:0] am_i,
                                 input logic bs_i, input logic [EW-1:0] be_i, input logic [DW-1:0] bm_i,
                                 input logic sub_i);
    res_t r;
    logic as, bs;
    logic [EW-1:0] ae, be;
    logic [63:0] am, bm, sm;
    int d;
    as = as_i; ae = ae_i; am = 64'(am_i) << 3;
    bs = bs_i ^ sub_i; be = be_i; bm = 64'(bm_i) << 3;
    if ({be_i, bm_i} > {ae_i, am_i}) begin
      as = bs; ae = be_i; am = 64'(bm_i) << 3;
      bs = as_i; be = ae_i; bm = 64'(am_i) << 3;
    end
    d = int'(ae) - int'(be);
    if (d >= MW) begin
      bm = (bm != 0) ? 64'd1 : 64'd0;
      r.lat = 3;
    end else begin
      // bit0 after d single-bit sticky shifts is the OR of original bits [d:0]
      bm = (bm >> d) | (((bm & ((64'd1 << (d + 1)) - 1)) != 0) ? 64'd1 : 64'd0);
      r.lat = 3 + d;
    end
    sm = (as == bs) ? am + bm : am - bm;
    if (sm[MW]) begin
      r.s = as;
      r.e = (ae == '1) ? ae : ae + 1'b1;
      r.m = MW'((sm >> 1) | (sm & 64'd1));
    end else if (sm == 0) begin
      r.s = 1'b0; r.e = '0; r.m = '0;
    end else begin
      r.s = as; r.e = ae; r.m = sm[MW-1:0];
    end
    r.t0 = 0;
    return r;
  endfunction

  // Drives one request starting just after a negedge; expectation queued once start is sampled
  task automatic issue(input logic as, input logic [EW-1:0] ae, input logic [DW-1:0] am,
                       input logic bs, input logic [EW-1:0] be, input logic [DW-1:0] bm,
                       input logic sb_in);
    res_t r;
    op_a_sign = as; op_a_exp = ae; op_a_man = am;
    op_b_sign = bs; op_b_exp = be; op_b_man = bm;
    sub = sb_in;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    r = model(as, ae, am, bs, be, bm, sb_in);
    r.t0 = cyc;
    sb.push_back(r);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      check_val("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    res_t r;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check_val("spurious_done", 64'd1, 64'd0);
      end else begin
        r = sb.pop_front();
        check_val("sign", 64'(sign_o), 64'(r.s));
        check_val("exp", 64'(exponent_o), 64'(r.e));
        check_val("man", 64'(mantissa_o), 64'(r.m));
        check_val("latency", 64'(cyc - r.t0), 64'(r.lat));
        check_val("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  localparam logic [DW-1:0] ONE = 24'h800000;

  initial begin
    logic [EW-1:0] ae, be;
    logic [DW-1:0] am, bm;
    int d;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0;
    op_a_sign = 1'b0; op_a_exp = '0; op_a_man = '0;
    op_b_sign = 1'b0; op_b_exp = '0; op_b_man = '0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_sign", 64'(sign_o), 64'd0);
    check_val("rst_exp", 64'(exponent_o), 64'd0);
    check_val("rst_man", 64'(mantissa_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Directed cases with hand-derived checks alongside the model
    issue(1'b0, 8'd127, ONE, 1'b0, 8'd127, ONE, 1'b0);
    wait_idle();
    check_val("1p1_man", 64'(mantissa_o), 64'h4000000);
    check_val("1p1_exp", 64'(exponent_o), 64'd128);
    issue(1'b0, 8'd127, ONE, 1'b0, 8'd125, ONE, 1'b0);
    wait_idle();
    check_val("1pq_man", 64'(mantissa_o), 64'h5000000);
    issue(1'b0, 8'd127, ONE, 1'b0, 8'd90, 24'h800001, 1'b0);
    wait_idle();
    check_val("far_man", 64'(mantissa_o), 64'h4000001);
    issue(1'b0, 8'd127, ONE, 1'b0, 8'd127, ONE, 1'b1);
    wait_idle();
    check_val("cancel_man", 64'(mantissa_o), 64'd0);
    issue(1'b0, 8'd127, ONE, 1'b0, 8'd128, ONE, 1'b1);
    wait_idle();
    check_val("swap_sign", 64'(sign_o), 64'd1);
    check_val("swap_man", 64'(mantissa_o), 64'h2000000);
    issue(1'b0, 8'd255, ONE, 1'b0, 8'd255, ONE, 1'b0);
    wait_idle();
    check_val("sat_exp", 64'(exponent_o), 64'd255);
    issue(1'b1, 8'd100, 24'hC00003, 1'b0, 8'd74, 24'hFFFFFF, 1'b0);
    wait_idle();
    issue(1'b0, 8'd100, 24'h000000, 1'b1, 8'd60, 24'h812345, 1'b1);
    wait_idle();

    // Start pulse during ALIGN must be ignored
    issue(1'b0, 8'd127, ONE, 1'b0, 8'd117, 24'hABCDEF, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    check_val("busy_mid", 64'(busy), 64'd1);
    op_a_exp = 8'd10; op_b_exp = 8'd10; sub = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);

    // Reset mid-ALIGN aborts with no done
    issue(1'b0, 8'd127, ONE, 1'b0, 8'd117, ONE, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_done", 64'(done), 64'd0);
    check_val("abort_sign", 64'(sign_o), 64'd0);
    check_val("abort_exp", 64'(exponent_o), 64'd0);
    check_val("abort_man", 64'(mantissa_o), 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    issue(1'b0, 8'd127, ONE, 1'b0, 8'd127, ONE, 1'b0);
    wait_idle();

    // Randomized back-to-back traffic
    for (int i = 0; i < 30; i++) begin
      ae = 8'($urandom_range(30, 220));
      d  = int'($urandom_range(0, 32));
      be = ($urandom_range(0, 1) != 0) ? ae - 8'(d) : ae + 8'(d);
      am = ($urandom_range(0, 9) == 0) ? '0 : {1'b1, 23'($urandom())};
      bm = ($urandom_range(0, 9) == 0) ? '0 : {1'b1, 23'($urandom())};
      if ($urandom_range(0, 5) == 0) begin
        be = ae; bm = am;
      end
      issue(1'($urandom()), ae, am, 1'($urandom()), be, bm, 1'($urandom()));
      wait_idle();
    end
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
